// File: rtl/checkpoint_ctrl_pkg.sv
// Shared types for the branch checkpoint controller.
//   ckpt_ctrl_state_e : recovery sequencer states
//   ckpt_meta_t       : per-slot bookkeeping (valid, resolved, ROB tag)
// The package constants describe the default configuration; the slot
// struct carries a CKPT_TAG_W-bit ROB tag, so instantiations must keep
// TAG_W equal to CKPT_TAG_W.
package types_pkg;
  localparam int NUM_CKPT   = 4;
  localparam int CKPT_IDW   = $clog2(NUM_CKPT);
  localparam int CKPT_TAG_W = 5;

  typedef enum logic [1:0] {IDLE, RESTORE, DRAIN} ckpt_ctrl_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  resolved;
    logic [CKPT_TAG_W-1:0] rob_tag;
  } ckpt_meta_t;
endpackage

// File: rtl/checkpoint_ctrl_ring_ptr.sv
// ckpt_ring_ptr: head/tail/occupancy ring for the checkpoint slots.
//   push      : allocate at tail (tail++, count++)
//   pop       : retire at head (head++, count--)
//   trunc     : cut the ring back to trunc_idx (tail <- idx, count <- idx-head)
//   head/tail : oldest live slot / next free slot, wrap modulo NUM_CKPT
//   count     : live slots, 0..NUM_CKPT
// trunc is never raised together with push or pop by the controller.
module ckpt_ring_ptr #(
  parameter int  NUM_CKPT = 4,
  localparam int IDW      = $clog2(NUM_CKPT)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           trunc,
  input  logic [IDW-1:0] trunc_idx,
  output logic [IDW-1:0] head,
  output logic [IDW-1:0] tail,
  output logic [IDW:0]   count
);
  logic [IDW-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDW:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q + IDW'(pop);
    tail_d  = tail_q + IDW'(push);
    count_d = count_q + (IDW+1)'(push) - (IDW+1)'(pop);
    if (trunc) begin
      // power-of-two ring: the subtraction wraps modulo NUM_CKPT for free
      tail_d  = trunc_idx;
      count_d = {1'b0, trunc_idx - head_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
endmodule

// File: rtl/checkpoint_ctrl.sv
// checkpoint_ctrl: allocation / recovery sequencer for branch checkpoints.
//   alloc_*    : Rename request, grant, slot index, storage write strobe
//   resolve_*  : branch resolution from Execute (correct or mispredict)
//   restore_*  : one-cycle restore pulse with slot index and ROB flush tag
//   flush, recover_busy, full, count : pipeline control / occupancy
// Optional build macro CKPT_STATS_EN adds saturating 16-bit counters
// stat_mispredicts and stat_full_stalls.
module checkpoint_ctrl #(
  parameter int  NUM_CKPT       = 4,
  parameter int  TAG_W          = 5,
  parameter int  RECOVER_CYCLES = 2,
  localparam int IDW            = $clog2(NUM_CKPT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  input  logic [TAG_W-1:0] alloc_rob_tag,
  output logic             alloc_gnt,
  output logic [IDW-1:0]   alloc_id,
  output logic             ckpt_we,
  output logic             full,
  input  logic             resolve_valid,
  input  logic [IDW-1:0]   resolve_id,
  input  logic             resolve_mispredict,
  output logic             restore_valid,
  output logic [IDW-1:0]   restore_idx,
  output logic [TAG_W-1:0] restore_rob_tag,
  output logic             flush,
  output logic             recover_busy,
  output logic [IDW:0]     count
`ifdef CKPT_STATS_EN
  ,
  output logic [15:0]      stat_mispredicts,
  output logic [15:0]      stat_full_stalls
`endif
);
  import types_pkg::*;

  localparam int DCW = $clog2(RECOVER_CYCLES) + 1;

  ckpt_meta_t       slot_q [NUM_CKPT];
  ckpt_meta_t       slot_d [NUM_CKPT];
  ckpt_ctrl_state_e state_q;
  logic [IDW-1:0]   idx_q;
  logic [DCW-1:0]   drain_cnt_q;
  logic [IDW-1:0]   head, tail, kill_off, off;
  logic             in_restore, mp_accept, resolve_ok, retire;

  assign in_restore = (state_q == RESTORE);
  // Execute was already flushed in the RESTORE cycle, so its mispredicts are stale
  assign mp_accept  = resolve_valid & resolve_mispredict & slot_q[resolve_id].valid & ~in_restore;
  assign resolve_ok = resolve_valid & ~resolve_mispredict & slot_q[resolve_id].valid;
  assign retire     = ~in_restore & slot_q[head].valid & slot_q[head].resolved;

  assign full      = (count == (IDW+1)'(NUM_CKPT));
  assign alloc_gnt = alloc_req & ~full & (state_q == IDLE) & ~(resolve_valid & resolve_mispredict);
  assign alloc_id  = tail;
  assign ckpt_we   = alloc_gnt;

  assign restore_valid   = in_restore;
  assign flush           = in_restore;
  assign restore_idx     = idx_q;
  assign restore_rob_tag = in_restore ? TAG_W'(slot_q[idx_q].rob_tag) : '0;
  assign recover_busy    = (state_q != IDLE);

  ckpt_ring_ptr #(.NUM_CKPT(NUM_CKPT)) u_ring (
    .clk       (clk),
    .reset     (reset),
    .push      (alloc_gnt),
    .pop       (retire),
    .trunc     (in_restore),
    .trunc_idx (idx_q),
    .head      (head),
    .tail      (tail),
    .count     (count)
  );

  always_comb begin
    slot_d   = slot_q;
    kill_off = idx_q - head;
    off      = '0;
    if (resolve_ok) slot_d[resolve_id].resolved = 1'b1;
    if (retire)     slot_d[head].valid = 1'b0;
    if (alloc_gnt) begin
      slot_d[tail].valid    = 1'b1;
      slot_d[tail].resolved = 1'b0;
      slot_d[tail].rob_tag  = alloc_rob_tag;
    end
    // Squash the mispredicted slot and everything younger. Age is measured
    // as distance from head, which also covers a full ring where tail == head.
    if (in_restore) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        off = IDW'(i) - head;
        if (off >= kill_off) slot_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CKPT; i++)
      slot_q[i] <= reset ? '0 : slot_d[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (mp_accept) begin
          state_q <= RESTORE;
          idx_q   <= resolve_id;
        end
        RESTORE: begin
          state_q     <= DRAIN;
          drain_cnt_q <= DCW'(RECOVER_CYCLES - 1);
        end
        DRAIN: begin
          if (mp_accept) begin
            state_q <= RESTORE;
            idx_q   <= resolve_id;
          end else if (drain_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CKPT_STATS_EN
  logic [15:0] stat_mis_q, stat_mis_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_mis_d   = stat_mis_q;
    stat_stall_d = stat_stall_q;
    if (mp_accept && stat_mis_q != 16'hffff)            stat_mis_d   = stat_mis_q + 16'd1;
    if (alloc_req && full && stat_stall_q != 16'hffff) stat_stall_d = stat_stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_mis_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_mis_q   <= stat_mis_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_mispredicts = stat_mis_q;
  assign stat_full_stalls = stat_stall_q;
`endif
endmodule

// File: tb/tb_checkpoint_ctrl.sv
// Directed bench for checkpoint_ctrl: fill, in-order retire, mispredict
// recovery, pointer wrap, collisions and reset during recovery.
module tb_checkpoint_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_req = 1'b0;
  logic [4:0] alloc_rob_tag = '0;
  logic       alloc_gnt;
  logic [1:0] alloc_id;
  logic       ckpt_we;
  logic       full;
  logic       resolve_valid = 1'b0;
  logic [1:0] resolve_id = '0;
  logic       resolve_mispredict = 1'b0;
  logic       restore_valid;
  logic [1:0] restore_idx;
  logic [4:0] restore_rob_tag;
  logic       flush;
  logic       recover_busy;
  logic [2:0] count;
`ifdef CKPT_STATS_EN
  logic [15:0] stat_mispredicts, stat_full_stalls;
`endif

  int total = 0;
  int bad   = 0;

  checkpoint_ctrl #(.NUM_CKPT(4), .TAG_W(5), .RECOVER_CYCLES(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .alloc_req          (alloc_req),
    .alloc_rob_tag      (alloc_rob_tag),
    .alloc_gnt          (alloc_gnt),
    .alloc_id           (alloc_id),
    .ckpt_we            (ckpt_we),
    .full               (full),
    .resolve_valid      (resolve_valid),
    .resolve_id         (resolve_id),
    .resolve_mispredict (resolve_mispredict),
    .restore_valid      (restore_valid),
    .restore_idx        (restore_idx),
    .restore_rob_tag    (restore_rob_tag),
    .flush              (flush),
    .recover_busy       (recover_busy),
    .count              (count)
`ifdef CKPT_STATS_EN
    ,
    .stat_mispredicts   (stat_mispredicts),
    .stat_full_stalls   (stat_full_stalls)
`endif
  );

  always #5 clk = ~clk;

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_req = 0; resolve_valid = 0; resolve_mispredict = 0;
    reset = 1; tick(); reset = 0;
  endtask

  task automatic do_fill(input int n, input int tag0);
    for (int k = 0; k < n; k++) begin
      alloc_req = 1; alloc_rob_tag = 5'(tag0 + k); tick();
    end
    alloc_req = 0;
  endtask

  task automatic resolve(input int id, input logic mp);
    resolve_valid = 1; resolve_id = 2'(id); resolve_mispredict = mp;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({full, recover_busy, restore_valid, flush, alloc_gnt, ckpt_we} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {full, recover_busy, restore_valid, flush, alloc_gnt, ckpt_we}); end
    total++; if (alloc_id !== 2'd0) begin bad++; $display("FAIL reset_alloc_id got=%0d exp=0", alloc_id); end
    reset = 0; tick();
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      alloc_req = 1; alloc_rob_tag = 5'(3 + k); #1;
      total++; if (alloc_gnt !== 1'b1 || ckpt_we !== 1'b1 || alloc_id !== 2'(k)) begin
        bad++; $display("FAIL fill_grant%0d gnt=%b we=%b id=%0d exp gnt=1 we=1 id=%0d", k, alloc_gnt, ckpt_we, alloc_id, k); end
      tick();
    end
    total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL fill_full full=%b count=%0d exp full=1 count=4", full, count); end
    #1;
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL fill_5th_refused gnt=%b exp=0", alloc_gnt); end
    alloc_req = 0;
  endtask

  task automatic test_in_order_retire();
    do_reset(); do_fill(4, 3);
    resolve(1, 0); tick(); resolve_valid = 0; tick();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL retire_out_of_order count=%0d exp=4", count); end
    resolve(0, 0); tick(); resolve_valid = 0;
    // retire of slot 0 pending this cycle, but full is still set
    alloc_req = 1; alloc_rob_tag = 5'd8; #1;
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL full_plus_retire gnt=%b exp=0", alloc_gnt); end
    tick();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL retire_slot0 count=%0d exp=3", count); end
    total++; if (alloc_gnt !== 1'b1 || alloc_id !== 2'd0) begin
      bad++; $display("FAIL grant_after_retire gnt=%b id=%0d exp gnt=1 id=0", alloc_gnt, alloc_id); end
    tick(); alloc_req = 0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL grant_with_retire count=%0d exp=3", count); end
    tick();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL retire_stops_unresolved count=%0d exp=3", count); end
  endtask

  task automatic test_mispredict();
    do_reset(); do_fill(4, 3);
    resolve(1, 1); tick(); resolve_valid = 0; resolve_mispredict = 0;
    alloc_req = 1; alloc_rob_tag = 5'd9; #1;
    total++; if ({restore_valid, flush, recover_busy} !== 3'b111 || restore_idx !== 2'd1 || restore_rob_tag !== 5'd4) begin
      bad++; $display("FAIL mp_restore rv/fl/busy=%b idx=%0d tag=%0d exp 111 idx=1 tag=4", {restore_valid, flush, recover_busy}, restore_idx, restore_rob_tag); end
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL mp_alloc_block_restore gnt=%b exp=0", alloc_gnt); end
    tick();
    total++; if (count !== 3'd1 || alloc_id !== 2'd1 || restore_valid !== 1'b0) begin
      bad++; $display("FAIL mp_truncate count=%0d tail=%0d rv=%b exp count=1 tail=1 rv=0", count, alloc_id, restore_valid); end
    total++; if (recover_busy !== 1'b1 || alloc_gnt !== 1'b0) begin bad++; $display("FAIL mp_drain1 busy=%b gnt=%b exp busy=1 gnt=0", recover_busy, alloc_gnt); end
    tick();
    total++; if (recover_busy !== 1'b1 || alloc_gnt !== 1'b0) begin bad++; $display("FAIL mp_drain2 busy=%b gnt=%b exp busy=1 gnt=0", recover_busy, alloc_gnt); end
    tick();
    total++; if (recover_busy !== 1'b0 || alloc_gnt !== 1'b1 || alloc_id !== 2'd1) begin
      bad++; $display("FAIL mp_resume busy=%b gnt=%b id=%0d exp busy=0 gnt=1 id=1", recover_busy, alloc_gnt, alloc_id); end
    tick(); alloc_req = 0;
    total++; if (count !== 3'd2) begin bad++; $display("FAIL mp_realloc count=%0d exp=2", count); end
  endtask

  task automatic test_wrap();
    do_reset(); do_fill(4, 3);
    resolve(0, 0); tick(); resolve(1, 0); tick(); resolve(2, 0); tick();
    resolve_valid = 0; tick(); tick();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL wrap_retire count=%0d exp=1", count); end
    alloc_req = 1; alloc_rob_tag = 5'd7; #1;
    total++; if (alloc_gnt !== 1'b1 || alloc_id !== 2'd0) begin bad++; $display("FAIL wrap_alloc gnt=%b id=%0d exp gnt=1 id=0", alloc_gnt, alloc_id); end
    tick(); alloc_req = 0;
    resolve(3, 1); tick(); resolve_valid = 0; resolve_mispredict = 0;
    total++; if (restore_idx !== 2'd3 || restore_rob_tag !== 5'd6 || restore_valid !== 1'b1) begin
      bad++; $display("FAIL wrap_restore rv=%b idx=%0d tag=%0d exp rv=1 idx=3 tag=6", restore_valid, restore_idx, restore_rob_tag); end
    tick();
    total++; if (count !== 3'd0 || alloc_id !== 2'd3) begin bad++; $display("FAIL wrap_truncate count=%0d tail=%0d exp count=0 tail=3", count, alloc_id); end
    tick(); tick();
    alloc_req = 1; #1;
    total++; if (alloc_gnt !== 1'b1 || alloc_id !== 2'd3) begin bad++; $display("FAIL wrap_next_grant gnt=%b id=%0d exp gnt=1 id=3", alloc_gnt, alloc_id); end
    tick(); alloc_req = 0;
  endtask

  task automatic test_collisions();
    do_reset(); do_fill(3, 3);
    alloc_req = 1; resolve(0, 1); #1;
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL coll_alloc_vs_mp gnt=%b exp=0", alloc_gnt); end
    tick(); alloc_req = 0; resolve_valid = 0; resolve_mispredict = 0;
    total++; if (restore_valid !== 1'b1 || restore_idx !== 2'd0 || restore_rob_tag !== 5'd3) begin
      bad++; $display("FAIL coll_restore0 rv=%b idx=%0d tag=%0d exp rv=1 idx=0 tag=3", restore_valid, restore_idx, restore_rob_tag); end
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL coll_count0 count=%0d exp=0", count); end

    // nested: slot 2 mispredict, stale mispredict in RESTORE ignored, slot 0 in DRAIN taken
    do_reset(); do_fill(4, 3);
    resolve(2, 1); tick();
    resolve(0, 1); tick(); resolve_valid = 0; resolve_mispredict = 0;
    total++; if (restore_valid !== 1'b0 || count !== 3'd2) begin
      bad++; $display("FAIL nest_ignore_in_restore rv=%b count=%0d exp rv=0 count=2", restore_valid, count); end
    resolve(0, 1); tick(); resolve_valid = 0; resolve_mispredict = 0;
    total++; if (restore_valid !== 1'b1 || restore_idx !== 2'd0 || restore_rob_tag !== 5'd3) begin
      bad++; $display("FAIL nest_restore0 rv=%b idx=%0d tag=%0d exp rv=1 idx=0 tag=3", restore_valid, restore_idx, restore_rob_tag); end
    tick();
    total++; if (count !== 3'd0 || alloc_id !== 2'd0) begin bad++; $display("FAIL nest_truncate count=%0d tail=%0d exp 0 0", count, alloc_id); end
    tick(); tick();
  endtask

  task automatic test_reset_drain();
    do_reset(); do_fill(4, 3);
    resolve(1, 1); tick(); resolve_valid = 0; resolve_mispredict = 0;
    tick();
    total++; if (recover_busy !== 1'b1 || count !== 3'd1) begin bad++; $display("FAIL rd_in_drain busy=%b count=%0d exp busy=1 count=1", recover_busy, count); end
    reset = 1; tick(); reset = 0;
    total++; if (count !== 3'd0 || recover_busy !== 1'b0 || alloc_id !== 2'd0 || full !== 1'b0) begin
      bad++; $display("FAIL rd_cleared count=%0d busy=%b id=%0d full=%b exp 0 0 0 0", count, recover_busy, alloc_id, full); end
`ifdef CKPT_STATS_EN
    total++; if (stat_mispredicts !== 16'd0 || stat_full_stalls !== 16'd0) begin
      bad++; $display("FAIL rd_stats mis=%0d stall=%0d exp 0 0", stat_mispredicts, stat_full_stalls); end
`endif
    tick();
    total++; if (recover_busy !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL rd_stays_idle busy=%b count=%0d exp 0 0", recover_busy, count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_in_order_retire();
    test_mispredict();
    test_wrap();
    test_collisions();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
